// File: rtl/volatility_pkg.sv
// rtl/volatility_pkg.sv - width helpers shared by the volatility window datapath.
package volatility_pkg;

   localparam int DEF_NUM_STOCKS  = 4;
   localparam int DEF_BUFFER_SIZE = 20;
   localparam int DEF_DATA_WIDTH  = 32;

   function automatic int f_cnt_w(input int buffer_size);
      return $clog2(buffer_size + 1);
   endfunction

   function automatic int f_sum_w(input int data_width, input int buffer_size);
      return data_width + f_cnt_w(buffer_size);
   endfunction

   function automatic int f_sq_w(input int data_width, input int buffer_size);
      return 2 * data_width + f_cnt_w(buffer_size);
   endfunction

   function automatic int f_var_w(input int data_width, input int buffer_size);
      return 2 * data_width + 2 * f_cnt_w(buffer_size);
   endfunction

   localparam int CNT_W = f_cnt_w(DEF_BUFFER_SIZE);
   localparam int SUM_W = f_sum_w(DEF_DATA_WIDTH, DEF_BUFFER_SIZE);
   localparam int SQ_W  = f_sq_w(DEF_DATA_WIDTH, DEF_BUFFER_SIZE);
   localparam int VAR_W = f_var_w(DEF_DATA_WIDTH, DEF_BUFFER_SIZE);

endpackage

// File: rtl/volatility_window_mem.sv
// rtl/volatility_window_mem.sv - price window storage with per-slot valid bits.
// Async read, sync write; a stock clear drops all of that stock's valid bits.
module volatility_window_mem
   import volatility_pkg::*;
#(
   parameter int NUM_STOCKS  = DEF_NUM_STOCKS,
   parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   localparam int DEPTH      = NUM_STOCKS * BUFFER_SIZE,
   localparam int ADDR_W     = $clog2(DEPTH),
   localparam int STK_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [ADDR_W-1:0]     i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid,
   input  logic                  i_wr_en,
   input  logic [ADDR_W-1:0]     i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_clr_en,
   input  logic [STK_W-1:0]      i_clr_stock
);

   logic [DATA_WIDTH-1:0] r_price [DEPTH];
   logic [DEPTH-1:0]      r_valid;

   assign o_rd_data  = r_price[i_rd_addr];
   assign o_rd_valid = r_valid[i_rd_addr];

   // Prices are never reset; stale contents are masked by r_valid.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_price[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_clr_en && (i_clr_stock == STK_W'(i / BUFFER_SIZE))) begin
               r_valid[i] <= 1'b0;
            end else if (i_wr_en && (i_wr_addr == ADDR_W'(i))) begin
               r_valid[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/volatility_calc.sv
// rtl/volatility_calc.sv - per-stock running count/sum/sum-of-squares over a price window.
// Two-stage pipeline emitting the division-free variance numerator N*sum(x^2) - sum(x)^2.
module volatility_calc
   import volatility_pkg::*;
#(
   parameter int NUM_STOCKS  = DEF_NUM_STOCKS,
   parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   localparam int DEPTH      = NUM_STOCKS * BUFFER_SIZE,
   localparam int ADDR_W     = $clog2(DEPTH),
   localparam int STK_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
   localparam int CNT_W      = f_cnt_w(BUFFER_SIZE),
   localparam int SUM_W      = f_sum_w(DATA_WIDTH, BUFFER_SIZE),
   localparam int SQ_W       = f_sq_w(DATA_WIDTH, BUFFER_SIZE),
   localparam int VAR_W      = f_var_w(DATA_WIDTH, BUFFER_SIZE)
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_addr_valid,
   input  logic [ADDR_W-1:0]     i_write_address,
   input  logic [STK_W-1:0]      i_stock_id,
   input  logic [DATA_WIDTH-1:0] i_price,
   input  logic                  i_flush,
   input  logic [STK_W-1:0]      i_flush_stock,
   output logic                  o_valid,
   output logic [STK_W-1:0]      o_stock_id,
   output logic [CNT_W-1:0]      o_count,
   output logic [SUM_W-1:0]      o_sum,
   output logic [VAR_W-1:0]      o_var_num,
   output logic                  o_error
);

   typedef struct packed {
      logic [STK_W-1:0] stock;
      logic [CNT_W-1:0] count;
      logic [SUM_W-1:0] sum;
      logic [SQ_W-1:0]  sumsq;
   } s1_result_t;

   logic [CNT_W-1:0] r_count [NUM_STOCKS];
   logic [SUM_W-1:0] r_sum   [NUM_STOCKS];
   logic [SQ_W-1:0]  r_sumsq [NUM_STOCKS];

   s1_result_t r_s1;
   logic       r_s1_valid;
   logic       r_s1_err;

   logic [31:0]           w_base;
   logic [31:0]           w_addr32;
   logic                  w_in_range;
   logic                  w_flush_hit;
   logic                  w_wr_en;
   logic                  w_err;
   logic [DATA_WIDTH-1:0] w_old_price;
   logic                  w_old_valid;
   logic [SUM_W-1:0]      w_old_term;
   logic [SQ_W-1:0]       w_old_sq;
   logic [SQ_W-1:0]       w_new_sq;
   logic [CNT_W-1:0]      w_new_cnt;
   logic [SUM_W-1:0]      w_new_sum;
   logic [SQ_W-1:0]       w_new_sumsq;
   logic [VAR_W-1:0]      w_var;

   assign w_base      = 32'(i_stock_id) * 32'(BUFFER_SIZE);
   assign w_addr32    = 32'(i_write_address);
   assign w_in_range  = (w_addr32 >= w_base) && (w_addr32 < (w_base + 32'(BUFFER_SIZE)));
   // A flush on the same stock silently swallows the write, error included.
   assign w_flush_hit = i_flush && (i_flush_stock == i_stock_id);
   assign w_wr_en     = i_addr_valid && w_in_range && !w_flush_hit;
   assign w_err       = i_addr_valid && !w_in_range && !w_flush_hit;

   volatility_window_mem #(
      .NUM_STOCKS  (NUM_STOCKS),
      .BUFFER_SIZE (BUFFER_SIZE),
      .DATA_WIDTH  (DATA_WIDTH)
   ) u_mem (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_rd_addr   (i_write_address),
      .o_rd_data   (w_old_price),
      .o_rd_valid  (w_old_valid),
      .i_wr_en     (w_wr_en),
      .i_wr_addr   (i_write_address),
      .i_wr_data   (i_price),
      .i_clr_en    (i_flush),
      .i_clr_stock (i_flush_stock)
   );

   assign w_old_term  = w_old_valid ? SUM_W'(w_old_price) : '0;
   assign w_old_sq    = w_old_valid ? SQ_W'(w_old_price) * SQ_W'(w_old_price) : '0;
   assign w_new_sq    = SQ_W'(i_price) * SQ_W'(i_price);
   assign w_new_cnt   = r_count[i_stock_id] + {{(CNT_W-1){1'b0}}, ~w_old_valid};
   assign w_new_sum   = r_sum[i_stock_id] + SUM_W'(i_price) - w_old_term;
   assign w_new_sumsq = r_sumsq[i_stock_id] + w_new_sq - w_old_sq;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            r_count[s] <= '0;
            r_sum[s]   <= '0;
            r_sumsq[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            if (i_flush && (i_flush_stock == STK_W'(s))) begin
               r_count[s] <= '0;
               r_sum[s]   <= '0;
               r_sumsq[s] <= '0;
            end else if (w_wr_en && (i_stock_id == STK_W'(s))) begin
               r_count[s] <= w_new_cnt;
               r_sum[s]   <= w_new_sum;
               r_sumsq[s] <= w_new_sumsq;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_s1       <= '0;
         r_s1_valid <= 1'b0;
         r_s1_err   <= 1'b0;
      end else begin
         r_s1_valid <= w_wr_en;
         r_s1_err   <= w_err;
         if (w_wr_en) begin
            r_s1.stock <= i_stock_id;
            r_s1.count <= w_new_cnt;
            r_s1.sum   <= w_new_sum;
            r_s1.sumsq <= w_new_sumsq;
         end
      end
   end

   // Cauchy-Schwarz keeps this non-negative, so no saturation is needed.
   assign w_var = VAR_W'(r_s1.count) * VAR_W'(r_s1.sumsq) - VAR_W'(r_s1.sum) * VAR_W'(r_s1.sum);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_valid    <= 1'b0;
         o_error    <= 1'b0;
         o_stock_id <= '0;
         o_count    <= '0;
         o_sum      <= '0;
         o_var_num  <= '0;
      end else begin
         o_valid <= r_s1_valid;
         o_error <= r_s1_err;
         if (r_s1_valid) begin
            o_stock_id <= r_s1.stock;
            o_count    <= r_s1.count;
            o_sum      <= r_s1.sum;
            o_var_num  <= w_var;
         end
      end
   end

endmodule

// File: tb/tb_volatility_calc.sv
// tb/tb_volatility_calc.sv - directed-vector bench for volatility_calc (4 stocks x 4 slots).
module tb_volatility_calc;

   logic        clk = 1'b0;
   logic        rst;
   logic        av;
   logic [3:0]  wa;
   logic [1:0]  sid;
   logic [31:0] price;
   logic        fl;
   logic [1:0]  fs;
   logic        ov;
   logic [1:0]  osid;
   logic [2:0]  ocnt;
   logic [34:0] osum;
   logic [69:0] ovar;
   logic        oerr;

   int     n_tests = 0;
   int     n_fail  = 0;
   int     p_kind;
   int     p_stk;
   int     p_cnt;
   longint p_sum;
   longint p_var;

   always #5 clk = ~clk;

   volatility_calc #(
      .NUM_STOCKS  (4),
      .BUFFER_SIZE (4),
      .DATA_WIDTH  (32)
   ) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_addr_valid    (av),
      .i_write_address (wa),
      .i_stock_id      (sid),
      .i_price         (price),
      .i_flush         (fl),
      .i_flush_stock   (fs),
      .o_valid         (ov),
      .o_stock_id      (osid),
      .o_count         (ocnt),
      .o_sum           (osum),
      .o_var_num       (ovar),
      .o_error         (oerr)
   );

   task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs; kind 0=no output, 1=result, 2=error expected two edges later.
   task automatic cyc(input logic v, input int a, input int s, input int p,
                      input logic f, input int fsk,
                      input int kind, input int ecnt, input longint esum, input longint evar);
      av    = v;
      wa    = 4'(a);
      sid   = 2'(s);
      price = 32'(p);
      fl    = f;
      fs    = 2'(fsk);
      @(negedge clk);
      av = 1'b0;
      fl = 1'b0;
      check("o_valid", 70'(ov), 70'(p_kind == 1));
      check("o_error", 70'(oerr), 70'(p_kind == 2));
      if (p_kind == 1) begin
         check("o_stock_id", 70'(osid), 70'(p_stk));
         check("o_count", 70'(ocnt), 70'(p_cnt));
         check("o_sum", 70'(osum), 70'(p_sum));
         check("o_var_num", ovar, 70'(p_var));
      end
      p_kind = kind;
      p_stk  = s;
      p_cnt  = ecnt;
      p_sum  = esum;
      p_var  = evar;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " o_valid"}, 70'(ov), 70'd0);
      check({tag, " o_error"}, 70'(oerr), 70'd0);
      check({tag, " o_stock_id"}, 70'(osid), 70'd0);
      check({tag, " o_count"}, 70'(ocnt), 70'd0);
      check({tag, " o_sum"}, 70'(osum), 70'd0);
      check({tag, " o_var_num"}, ovar, 70'd0);
   endtask

   initial begin
      rst = 1'b1; av = 1'b0; wa = '0; sid = '0; price = '0; fl = 1'b0; fs = '0;
      p_kind = 0; p_stk = 0; p_cnt = 0; p_sum = 0; p_var = 0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Fill stock 1, then wrap onto slot 4
      cyc(1, 4, 1, 10, 0, 0, 1, 1, 10, 0);
      cyc(1, 5, 1, 20, 0, 0, 1, 2, 30, 100);
      cyc(1, 6, 1, 30, 0, 0, 1, 3, 60, 600);
      cyc(1, 7, 1, 40, 0, 0, 1, 4, 100, 2000);
      cyc(1, 4, 1, 90, 0, 0, 1, 4, 180, 11600);
      // Out-of-range address for stock 0
      cyc(1, 9, 0, 1, 0, 0, 2, 0, 0, 0);
      cyc(1, 0, 0, 5, 0, 0, 1, 1, 5, 0);
      // Flush with a same-stock write: nothing emitted
      cyc(1, 5, 1, 50, 1, 1, 0, 0, 0, 0);
      cyc(1, 6, 1, 7, 0, 0, 1, 1, 7, 0);
      // Interleaved stocks 0 and 2
      cyc(1, 1, 0, 3, 0, 0, 1, 2, 8, 4);
      cyc(1, 8, 2, 4, 0, 0, 1, 1, 4, 0);
      cyc(1, 2, 0, 3, 0, 0, 1, 3, 11, 8);
      cyc(1, 9, 2, 4, 0, 0, 1, 2, 8, 0);
      cyc(1, 3, 0, 3, 0, 0, 1, 4, 14, 12);
      cyc(1, 10, 2, 4, 0, 0, 1, 3, 12, 0);
      // Flush stock 2 while overwriting stock 0 slot 0 (5 -> 6)
      cyc(1, 0, 0, 6, 1, 2, 1, 4, 15, 27);
      cyc(1, 8, 2, 4, 0, 0, 1, 1, 4, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset between a write and its result
      cyc(1, 11, 2, 9, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      check_zero("midreset");
      rst = 1'b0;
      @(negedge clk);
      check_zero("postreset");
      p_kind = 0;
      cyc(1, 11, 2, 9, 0, 0, 1, 1, 9, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
